// File: rtl/pipeline_hazard_ctrl.sv
// Stall/flush scheduler for the 5-stage pipeline: load-use and branch hazards,
// mult/div busy sequencing, and exception/ERET flush of IF/ID, ID/EX and EX/MEM.
module pipeline_hazard_ctrl #(
  parameter int unsigned MULT_CYCLES = 5,
  parameter int unsigned DIV_CYCLES  = 10,
  parameter int unsigned CNT_W       = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [4:0] RsD,
  input  logic [4:0] RtD,
  input  logic       UseRsD,
  input  logic       UseRtD,
  input  logic       BranchD,
  input  logic [4:0] RegAddrE,
  input  logic       MemtoRegE,
  input  logic       RegWriteE,
  input  logic [4:0] RegAddrM,
  input  logic       MemtoRegM,
  input  logic       MdStartE,
  input  logic       MdTypeE,
  input  logic       MdUseD,
  input  logic       ExcOccurM,
  input  logic       EretM,
  output logic       StallF,
  output logic       StallD,
  output logic       ClrD,
  output logic       ClrE,
  output logic       ClrM,
  output logic       MdBusy
);

  typedef enum logic {IDLE, BUSY} mdState_t;

  // The start cycle already counts as busy, so BUSY lasts N-1 further cycles.
  localparam logic [CNT_W-1:0] MULT_LOAD = CNT_W'(MULT_CYCLES - 1);
  localparam logic [CNT_W-1:0] DIV_LOAD  = CNT_W'(DIV_CYCLES - 1);

  mdState_t         state;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] loadVal;
  logic             luHaz, brHaz, mdHaz, stall, flush, mdStart, busyNow;

  always_comb begin
    luHaz = MemtoRegE && RegWriteE && (RegAddrE != '0) &&
            ((UseRsD && (RsD == RegAddrE)) || (UseRtD && (RtD == RegAddrE)));
    brHaz = BranchD &&
            ((RegWriteE && (RegAddrE != '0) && ((RsD == RegAddrE) || (RtD == RegAddrE))) ||
             (MemtoRegM && (RegAddrM != '0) && ((RsD == RegAddrM) || (RtD == RegAddrM))));
    flush   = ExcOccurM || EretM;
    mdStart = MdStartE && !flush;
    busyNow = (state == BUSY) || mdStart;
    mdHaz   = MdUseD && busyNow;
    stall   = luHaz || brHaz || mdHaz;
    loadVal = MdTypeE ? DIV_LOAD : MULT_LOAD;
  end

  always_comb begin
    StallF = 1'b0;
    StallD = 1'b0;
    ClrD   = 1'b0;
    ClrE   = 1'b0;
    ClrM   = 1'b0;
    MdBusy = busyNow && !reset;
    if (reset || flush) begin
      ClrD = 1'b1;
      ClrE = 1'b1;
      ClrM = 1'b1;
    end else if (stall) begin
      StallF = 1'b1;
      StallD = 1'b1;
      ClrE   = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (mdStart && (loadVal != '0)) begin
            state <= BUSY;
            cnt   <= loadVal;
          end
        end
        BUSY: begin
          if (cnt <= CNT_W'(1)) begin
            state <= IDLE;
            cnt   <= '0;
          end else begin
            cnt <= cnt - CNT_W'(1);
          end
        end
        default: begin
          state <= IDLE;
          cnt   <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Directed self-checking bench for pipeline_hazard_ctrl; outputs are compared as
// the vector {StallF, StallD, ClrD, ClrE, ClrM, MdBusy}.
module tb_pipeline_hazard_ctrl;

  logic       clk = 1'b0;
  logic       reset;
  logic [4:0] RsD, RtD, RegAddrE, RegAddrM;
  logic       UseRsD, UseRtD, BranchD, MemtoRegE, RegWriteE, MemtoRegM;
  logic       MdStartE, MdTypeE, MdUseD, ExcOccurM, EretM;
  logic       StallF, StallD, ClrD, ClrE, ClrM, MdBusy;
  logic [5:0] obs;

  int unsigned nTests = 0;
  int unsigned nFails = 0;

  localparam logic [5:0] IDLE_V  = 6'b000000;
  localparam logic [5:0] STALL_V = 6'b110100;
  localparam logic [5:0] FLUSH_V = 6'b001110;
  localparam logic [5:0] BUSY_V  = 6'b000001;
  localparam logic [5:0] MDST_V  = 6'b110101;

  pipeline_hazard_ctrl #(.MULT_CYCLES(5), .DIV_CYCLES(10), .CNT_W(4)) dut (
    .clk(clk), .reset(reset), .RsD(RsD), .RtD(RtD), .UseRsD(UseRsD), .UseRtD(UseRtD),
    .BranchD(BranchD), .RegAddrE(RegAddrE), .MemtoRegE(MemtoRegE), .RegWriteE(RegWriteE),
    .RegAddrM(RegAddrM), .MemtoRegM(MemtoRegM), .MdStartE(MdStartE), .MdTypeE(MdTypeE),
    .MdUseD(MdUseD), .ExcOccurM(ExcOccurM), .EretM(EretM), .StallF(StallF), .StallD(StallD),
    .ClrD(ClrD), .ClrE(ClrE), .ClrM(ClrM), .MdBusy(MdBusy)
  );

  always #5 clk = ~clk;
  assign obs = {StallF, StallD, ClrD, ClrE, ClrM, MdBusy};

  task automatic clearInputs();
    reset = 1'b0; RsD = '0; RtD = '0; RegAddrE = '0; RegAddrM = '0;
    UseRsD = 1'b0; UseRtD = 1'b0; BranchD = 1'b0; MemtoRegE = 1'b0; RegWriteE = 1'b0;
    MemtoRegM = 1'b0; MdStartE = 1'b0; MdTypeE = 1'b0; MdUseD = 1'b0;
    ExcOccurM = 1'b0; EretM = 1'b0;
  endtask

  // Advance one clock; inputs then change 1 ns after the edge, sampling happens at +4 ns.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #3;
  endtask

  task automatic test_reset();
    clearInputs();
    reset = 1'b1; MdStartE = 1'b1; MdTypeE = 1'b1;
    settle();
    nTests++;
    if (obs !== FLUSH_V) begin nFails++; $display("FAIL reset_outputs got %b exp %b", obs, FLUSH_V); end
    tick(); tick();
    clearInputs();
    settle();
    nTests++;
    if (obs !== IDLE_V) begin nFails++; $display("FAIL post_reset_idle got %b exp %b", obs, IDLE_V); end
    tick();
  endtask

  task automatic test_load_use();
    clearInputs();
    MemtoRegE = 1'b1; RegWriteE = 1'b1; RegAddrE = 5'd8; RsD = 5'd8; UseRsD = 1'b1;
    settle();
    nTests++;
    if (obs !== STALL_V) begin nFails++; $display("FAIL lu_rs got %b exp %b", obs, STALL_V); end
    tick();
    RegAddrE = 5'd0; RsD = 5'd0;
    settle();
    nTests++;
    if (obs !== IDLE_V) begin nFails++; $display("FAIL lu_reg0 got %b exp %b", obs, IDLE_V); end
    tick();
    RegAddrE = 5'd12; RsD = 5'd12; UseRsD = 1'b0; RtD = 5'd3; UseRtD = 1'b1;
    settle();
    nTests++;
    if (obs !== IDLE_V) begin nFails++; $display("FAIL lu_rs_unused got %b exp %b", obs, IDLE_V); end
    tick();
    RtD = 5'd12;
    settle();
    nTests++;
    if (obs !== STALL_V) begin nFails++; $display("FAIL lu_rt got %b exp %b", obs, STALL_V); end
    tick();
    RegWriteE = 1'b0;
    settle();
    nTests++;
    if (obs !== IDLE_V) begin nFails++; $display("FAIL lu_nowrite got %b exp %b", obs, IDLE_V); end
    tick();
  endtask

  task automatic test_branch();
    clearInputs();
    BranchD = 1'b1; RsD = 5'd9; RegWriteE = 1'b1; RegAddrE = 5'd9;
    settle();
    nTests++;
    if (obs !== STALL_V) begin nFails++; $display("FAIL br_alu_e got %b exp %b", obs, STALL_V); end
    tick();
    RegWriteE = 1'b0; RegAddrE = 5'd0; MemtoRegM = 1'b1; RegAddrM = 5'd9;
    settle();
    nTests++;
    if (obs !== STALL_V) begin nFails++; $display("FAIL br_load_m got %b exp %b", obs, STALL_V); end
    tick();
    MemtoRegM = 1'b0;
    settle();
    nTests++;
    if (obs !== IDLE_V) begin nFails++; $display("FAIL br_alu_m_clear got %b exp %b", obs, IDLE_V); end
    tick();
    MemtoRegM = 1'b1; RegAddrM = 5'd4; RsD = 5'd1; RtD = 5'd4;
    settle();
    nTests++;
    if (obs !== STALL_V) begin nFails++; $display("FAIL br_load_m_rt got %b exp %b", obs, STALL_V); end
    tick();
    BranchD = 1'b0;
    settle();
    nTests++;
    if (obs !== IDLE_V) begin nFails++; $display("FAIL br_nobranch got %b exp %b", obs, IDLE_V); end
    tick();
  endtask

  task automatic runMd(input logic isDiv, input int unsigned n, input string name);
    clearInputs();
    MdStartE = 1'b1; MdTypeE = isDiv;
    settle();
    nTests++;
    if (obs !== BUSY_V) begin nFails++; $display("FAIL %s_start got %b exp %b", name, obs, BUSY_V); end
    tick();
    MdStartE = 1'b0; MdUseD = 1'b1;
    for (int i = 1; i < int'(n); i++) begin
      settle();
      nTests++;
      if (obs !== MDST_V) begin nFails++; $display("FAIL %s_busy_c%0d got %b exp %b", name, i, obs, MDST_V); end
      tick();
    end
    settle();
    nTests++;
    if (obs !== IDLE_V) begin nFails++; $display("FAIL %s_done got %b exp %b", name, obs, IDLE_V); end
    tick();
  endtask

  task automatic test_multdiv();
    runMd(1'b0, 5, "mult");
    runMd(1'b1, 10, "div");
  endtask

  task automatic test_flush();
    clearInputs();
    MemtoRegE = 1'b1; RegWriteE = 1'b1; RegAddrE = 5'd8; RsD = 5'd8; UseRsD = 1'b1;
    ExcOccurM = 1'b1; MdStartE = 1'b1;
    settle();
    nTests++;
    if (obs !== FLUSH_V) begin nFails++; $display("FAIL exc_over_lu got %b exp %b", obs, FLUSH_V); end
    tick();
    clearInputs();
    MdUseD = 1'b1;
    settle();
    nTests++;
    if (obs !== IDLE_V) begin nFails++; $display("FAIL exc_md_discard got %b exp %b", obs, IDLE_V); end
    tick();
    clearInputs();
    EretM = 1'b1;
    settle();
    nTests++;
    if (obs !== FLUSH_V) begin nFails++; $display("FAIL eret_alone got %b exp %b", obs, FLUSH_V); end
    tick();
  endtask

  task automatic test_reset_midbusy();
    clearInputs();
    MdStartE = 1'b1; MdTypeE = 1'b1;
    tick();
    MdStartE = 1'b0;
    repeat (6) tick();
    reset = 1'b1;
    settle();
    nTests++;
    if (obs !== FLUSH_V) begin nFails++; $display("FAIL rst_busy_during got %b exp %b", obs, FLUSH_V); end
    tick();
    reset = 1'b0;
    settle();
    nTests++;
    if (obs !== IDLE_V) begin nFails++; $display("FAIL rst_busy_after got %b exp %b", obs, IDLE_V); end
    tick();
  endtask

  task automatic test_eret_busy();
    clearInputs();
    MdStartE = 1'b1; MdTypeE = 1'b1;
    tick();
    MdStartE = 1'b0; MdUseD = 1'b1;
    repeat (3) tick();
    EretM = 1'b1;
    settle();
    nTests++;
    if (obs !== 6'b001111) begin nFails++; $display("FAIL eret_busy got %b exp %b", obs, 6'b001111); end
    tick();
    EretM = 1'b0;
    for (int i = 5; i < 10; i++) begin
      settle();
      nTests++;
      if (obs !== MDST_V) begin nFails++; $display("FAIL eret_cont_c%0d got %b exp %b", i, obs, MDST_V); end
      tick();
    end
    settle();
    nTests++;
    if (obs !== IDLE_V) begin nFails++; $display("FAIL eret_done got %b exp %b", obs, IDLE_V); end
    tick();
  endtask

  task automatic test_back_to_back();
    runMd(1'b0, 5, "b2b_mult");
    runMd(1'b1, 10, "b2b_div");
    runMd(1'b0, 5, "b2b_mult2");
  endtask

  initial begin
    clearInputs();
    reset = 1'b1;
    #1;
    test_reset();
    test_load_use();
    test_branch();
    test_multdiv();
    test_flush();
    test_reset_midbusy();
    test_eret_busy();
    test_back_to_back();
    $display("[TB] %0d tests run, %0d failed", nTests, nFails);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog got timeout exp finish");
    $fatal(1, "watchdog");
  end

endmodule
